axis_block_packer: RTL and testbench

AXIS_BLOCK_PACKER -- requirements
Module: axis_block_packer

---
 rtl/aes_axis_pkg.sv | 32 +++
 rtl/axis_keep_count.sv | 31 +++
 rtl/axis_block_packer.sv | 155 +++++++++++++++
 tb/tb_axis_block_packer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_axis_pkg.sv
// Shared constants, FSM encodings and tkeep helpers for the AES AXI-Stream path.
// Only a 128-bit (16-byte) stream is supported by these helpers.
package aes_axis_pkg;

    localparam int AES_BLK_BYTES = 16;
    localparam int AES_BLK_BITS  = AES_BLK_BYTES * 8;

    typedef enum logic {
        ACCUM = 1'b0,
        FLUSH = 1'b1
    } pack_state_t;

    // Low n bits set, n in 0..16.
    function automatic logic [AES_BLK_BYTES-1:0] keep_mask(input logic [4:0] n);
        logic [AES_BLK_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < AES_BLK_BYTES; i++) begin
            m[i] = (5'(i) < n);
        end
        return m;
    endfunction

    function automatic logic [AES_BLK_BITS-1:0] keep_to_bits(input logic [AES_BLK_BYTES-1:0] k);
        logic [AES_BLK_BITS-1:0] b;
        b = '0;
        for (int i = 0; i < AES_BLK_BYTES; i++) begin
            b[8*i +: 8] = {8{k[i]}};
        end
        return b;
    endfunction

endpackage

// File: rtl/axis_keep_count.sv
// Leading-ones count of tkeep from bit 0, plus a flag for any set bit above that run.
// Latency: combinational.
// Backpressure: none (pure function of tkeep).
module axis_keep_count #(
    parameter int KEEP_W = 16,
    parameter int CNT_W  = $clog2(KEEP_W + 1)
) (
    input  logic [KEEP_W-1:0] keep,
    output logic [CNT_W-1:0]  count,
    output logic              err
);

    logic run;

    always_comb begin
        run   = 1'b1;
        count = '0;
        err   = 1'b0;
        for (int i = 0; i < KEEP_W; i++) begin
            if (run && keep[i]) begin
                count = count + CNT_W'(1);
            end else begin
                run = 1'b0;
                if (keep[i]) begin
                    err = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/axis_block_packer.sv
// Repacks a byte-sparse AXI-Stream into dense 16-byte blocks (PACKER_STATS_EN enables byte/packet counters).
// Latency: one cycle from accepted input beat to output valid; a last beat with >16 bytes takes one extra FLUSH cycle.
// Backpressure: single output register; input is stalled while it is full and not draining, and during FLUSH.
module axis_block_packer
    import aes_axis_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              err_keep,
    input  logic              err_clr,
    output logic [31:0]       stat_bytes,
    output logic [31:0]       stat_pkts
);

    localparam int CNT_W = $clog2(KEEP_W + 1);

    pack_state_t       state_q;
    logic              run_q;
    logic [DATA_W-1:0] res_q;
    logic [3:0]        res_cnt_q;

    logic [CNT_W-1:0]    in_cnt;
    logic                keep_err;
    logic [DATA_W-1:0]   data_m;
    logic [2*DATA_W-1:0] merged;
    logic [CNT_W-1:0]    total;
    logic                can_load;
    logic                accept;
    logic                flush_load;

    axis_keep_count #(
        .KEEP_W (KEEP_W),
        .CNT_W  (CNT_W)
    ) u_keep_count (
        .keep  (s_axis_tkeep),
        .count (in_cnt),
        .err   (keep_err)
    );

    // Residue is kept zero above R bytes, so OR-merging yields zeros beyond T.
    assign data_m = s_axis_tdata & keep_to_bits(keep_mask(in_cnt));
    assign merged = {{DATA_W{1'b0}}, res_q} | ({{DATA_W{1'b0}}, data_m} << {res_cnt_q, 3'b000});
    assign total  = {1'b0, res_cnt_q} + in_cnt;

    assign can_load      = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = run_q && (state_q == ACCUM) && can_load;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign flush_load    = (state_q == FLUSH) && can_load;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= ACCUM;
            run_q         <= 1'b0;
            res_q         <= '0;
            res_cnt_q     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (can_load) begin
                m_axis_tvalid <= 1'b0;
            end
            if (accept) begin
                if (s_axis_tlast) begin
                    res_q     <= '0;
                    res_cnt_q <= '0;
                    if (total > CNT_W'(AES_BLK_BYTES)) begin
                        // Overflow bytes park in the residue register until FLUSH drains them.
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= merged[DATA_W-1:0];
                        m_axis_tkeep  <= '1;
                        m_axis_tlast  <= 1'b0;
                        res_q         <= merged[2*DATA_W-1:DATA_W];
                        res_cnt_q     <= total[3:0];
                        state_q       <= FLUSH;
                    end else if (total != '0) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= merged[DATA_W-1:0];
                        m_axis_tkeep  <= keep_mask(total);
                        m_axis_tlast  <= 1'b1;
                    end
                end else if (total >= CNT_W'(AES_BLK_BYTES)) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= merged[DATA_W-1:0];
                    m_axis_tkeep  <= '1;
                    m_axis_tlast  <= 1'b0;
                    res_q         <= merged[2*DATA_W-1:DATA_W];
                    res_cnt_q     <= total[3:0];
                end else begin
                    res_q     <= merged[DATA_W-1:0];
                    res_cnt_q <= total[3:0];
                end
            end else if (flush_load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= res_q;
                m_axis_tkeep  <= keep_mask({1'b0, res_cnt_q});
                m_axis_tlast  <= 1'b1;
                res_q         <= '0;
                res_cnt_q     <= '0;
                state_q       <= ACCUM;
            end
        end
    end

    // A new error in the same cycle as a clear wins.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_keep <= 1'b0;
        end else if (accept && keep_err) begin
            err_keep <= 1'b1;
        end else if (err_clr) begin
            err_keep <= 1'b0;
        end
    end

`ifdef PACKER_STATS_EN
    logic pkt_load;

    assign pkt_load = flush_load ||
                      (accept && s_axis_tlast && (total != '0) && (total <= CNT_W'(AES_BLK_BYTES)));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_bytes <= '0;
            stat_pkts  <= '0;
        end else begin
            if (accept) begin
                stat_bytes <= stat_bytes + 32'(in_cnt);
            end
            if (pkt_load) begin
                stat_pkts <= stat_pkts + 32'd1;
            end
        end
    end
`else
    assign stat_bytes = '0;
    assign stat_pkts  = '0;
`endif

endmodule

// File: tb/tb_axis_block_packer.sv
// Directed bench for axis_block_packer: output blocks collected by a monitor, compared to hand-built vectors.
module tb_axis_block_packer;

    logic         aclk;
    logic         aresetn;
    logic [127:0] s_axis_tdata;
    logic [15:0]  s_axis_tkeep;
    logic         s_axis_tlast;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [127:0] m_axis_tdata;
    logic [15:0]  m_axis_tkeep;
    logic         m_axis_tlast;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         err_keep;
    logic         err_clr;
    logic [31:0]  stat_bytes;
    logic [31:0]  stat_pkts;

    typedef struct {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } out_t;

    out_t outq[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    axis_block_packer #(.DATA_W(128), .KEEP_W(16)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .err_keep      (err_keep),
        .err_clr       (err_clr),
        .stat_bytes    (stat_bytes),
        .stat_pkts     (stat_pkts)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            outq.push_back('{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast});
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte i = start+i for i < n, otherwise junk.
    function automatic logic [127:0] mk(input logic [7:0] start, input int n, input logic [7:0] junk);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) begin
            v[8*i +: 8] = (i < n) ? start + 8'(i) : junk;
        end
        return v;
    endfunction

    // Called just after a posedge; returns just after the accepting posedge with tvalid still high.
    task automatic send(input logic [127:0] d, input logic [15:0] k, input logic l);
        bit done;
        done = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge aclk);
            if (s_axis_tready) begin
                @(posedge aclk);
                #1;
                done = 1;
            end
        end
        if (!done) chk("send_timeout", 1, 0);
    endtask

    task automatic idle_cycles(input int n);
        s_axis_tvalid = 1'b0;
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic exp_out(input string tag, input int idx, input logic [127:0] d,
                           input logic [15:0] k, input logic l);
        if (idx < outq.size()) begin
            chk({tag, "_data"}, outq[idx].d, d);
            chk({tag, "_keep"}, 128'(outq[idx].k), 128'(k));
            chk({tag, "_last"}, 128'(outq[idx].l), 128'(l));
        end else begin
            chk({tag, "_missing"}, 128'(outq.size()), 128'(idx + 1));
        end
    endtask

    logic [31:0] exp_pkts_mid;
    logic [31:0] exp_bytes_end;
    logic [31:0] exp_pkts_end;

    initial begin
        int c0;
        int c2;
`ifdef PACKER_STATS_EN
        exp_pkts_mid  = 32'd3;
        exp_bytes_end = 32'd4;
        exp_pkts_end  = 32'd1;
`else
        exp_pkts_mid  = 32'd0;
        exp_bytes_end = 32'd0;
        exp_pkts_end  = 32'd0;
`endif
        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        err_clr       = 1'b0;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_m_vld", 128'(m_axis_tvalid), 0);
        chk("rst_m_data", m_axis_tdata, 0);
        chk("rst_s_rdy", 128'(s_axis_tready), 0);
        chk("rst_err", 128'(err_keep), 0);
        chk("rst_stat_bytes", 128'(stat_bytes), 0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("rel_s_rdy_before_edge", 128'(s_axis_tready), 0);
        @(posedge aclk);
        #1;
        chk("rel_s_rdy_after_edge", 128'(s_axis_tready), 1);

        // Three full beats back to back
        send(mk(8'h10, 16, 8'h00), 16'hFFFF, 1'b0);
        c0 = cyc;
        chk("full_latency_vld", 128'(m_axis_tvalid), 1);
        send(mk(8'h20, 16, 8'h00), 16'hFFFF, 1'b0);
        send(mk(8'h30, 16, 8'h00), 16'hFFFF, 1'b1);
        c2 = cyc;
        chk("full_b2b_cycles", 128'(c2 - c0), 2);
        idle_cycles(4);
        chk("full_count", 128'(outq.size()), 3);
        exp_out("full0", 0, mk(8'h10, 16, 8'h00), 16'hFFFF, 1'b0);
        exp_out("full1", 1, mk(8'h20, 16, 8'h00), 16'hFFFF, 1'b0);
        exp_out("full2", 2, mk(8'h30, 16, 8'h00), 16'hFFFF, 1'b1);
        outq.delete();

        // Two half beats merge into one block
        send(mk(8'h00, 8, 8'hAA), 16'h00FF, 1'b0);
        send(mk(8'h08, 8, 8'hBB), 16'h00FF, 1'b1);
        idle_cycles(4);
        chk("half_count", 128'(outq.size()), 1);
        exp_out("half0", 0, mk(8'h00, 16, 8'h00), 16'hFFFF, 1'b1);
        outq.delete();

        // 12 + 12 bytes: full block then 8-byte tail via FLUSH
        send(mk(8'h40, 12, 8'h55), 16'h0FFF, 1'b0);
        send(mk(8'h4C, 12, 8'h66), 16'h0FFF, 1'b1);
        chk("flush_s_rdy", 128'(s_axis_tready), 0);
        idle_cycles(4);
        chk("flush_count", 128'(outq.size()), 2);
        exp_out("flush0", 0, mk(8'h40, 16, 8'h00), 16'hFFFF, 1'b0);
        exp_out("flush1", 1, mk(8'h50, 8, 8'h00), 16'h00FF, 1'b1);
        outq.delete();

        // Empty last beat, then non-contiguous keep
        send(mk(8'hF0, 0, 8'hF0), 16'h0000, 1'b1);
        idle_cycles(4);
        chk("empty_count", 128'(outq.size()), 0);
        chk("empty_stat_pkts", 128'(stat_pkts), 128'(exp_pkts_mid));
        send(mk(8'h60, 4, 8'hEE), 16'h0F0F, 1'b0);
        chk("gap_err_set", 128'(err_keep), 1);
        send(mk(8'h64, 1, 8'hEE), 16'h0001, 1'b1);
        idle_cycles(4);
        chk("gap_count", 128'(outq.size()), 1);
        exp_out("gap0", 0, mk(8'h60, 5, 8'h00), 16'h001F, 1'b1);
        outq.delete();
        err_clr = 1'b1;
        @(posedge aclk);
        #1;
        err_clr = 1'b0;
        chk("err_cleared", 128'(err_keep), 0);

        // Output stalled for 5 cycles with a second beat waiting
        m_axis_tready = 1'b0;
        send(mk(8'h70, 16, 8'h00), 16'hFFFF, 1'b0);
        s_axis_tdata  = mk(8'h80, 16, 8'h00);
        s_axis_tkeep  = 16'hFFFF;
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("stall_vld", 128'(m_axis_tvalid), 1);
            chk("stall_data", m_axis_tdata, mk(8'h70, 16, 8'h00));
            chk("stall_keep", 128'(m_axis_tkeep), 128'(16'hFFFF));
            chk("stall_s_rdy", 128'(s_axis_tready), 0);
        end
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
        send(mk(8'h80, 16, 8'h00), 16'hFFFF, 1'b1);
        idle_cycles(4);
        chk("stall_count", 128'(outq.size()), 2);
        exp_out("stall0", 0, mk(8'h70, 16, 8'h00), 16'hFFFF, 1'b0);
        exp_out("stall1", 1, mk(8'h80, 16, 8'h00), 16'hFFFF, 1'b1);
        outq.delete();

        // Reset mid-packet with 7 residue bytes and an output pending
        send(mk(8'h90, 7, 8'hCC), 16'h007F, 1'b0);
        m_axis_tready = 1'b0;
        send(mk(8'h97, 16, 8'h00), 16'hFFFF, 1'b0);
        s_axis_tvalid = 1'b0;
        #1;
        aresetn = 1'b0;
        #1;
        chk("arst_m_vld", 128'(m_axis_tvalid), 0);
        chk("arst_m_data", m_axis_tdata, 0);
        chk("arst_s_rdy", 128'(s_axis_tready), 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("arst_s_rdy_after", 128'(s_axis_tready), 1);
        chk("arst_stat_pkts", 128'(stat_pkts), 0);
        outq.delete();
        m_axis_tready = 1'b1;
        send(mk(8'hA0, 4, 8'hDD), 16'h000F, 1'b1);
        idle_cycles(4);
        chk("post_rst_count", 128'(outq.size()), 1);
        exp_out("post_rst0", 0, mk(8'hA0, 4, 8'h00), 16'h000F, 1'b1);
        chk("end_stat_bytes", 128'(stat_bytes), 128'(exp_bytes_end));
        chk("end_stat_pkts", 128'(stat_pkts), 128'(exp_pkts_end));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
